// File: rtl/cp0_priv_hazard.sv
// ID-stage COP0 pre-decoder with an in-flight MTC0 tracker and CP0 read-after-write stall.
// Tracks uncommitted MTC0 addresses from EX to the CP0 commit stage.
module cp0_priv_hazard #(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned SEL_CMP = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrD,
  input  logic             validD,
  input  logic             adv,
  input  logic             flush_all,
  output logic             id_is_eret,
  output logic             id_is_mtc0,
  output logic             id_is_mfc0,
  output logic [7:0]       id_cp0_addr,
  output logic             stall_cp0,
  output logic [3:0]       pend_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [31:0] EretWord = 32'h4200_0018;
  localparam logic [5:0]  OpCop0   = 6'b010000;
  localparam logic [4:0]  RsMt     = 5'b00100;
  localparam logic [4:0]  RsMf     = 5'b00000;
  localparam logic [4:0]  RegEpc    = 5'd14;
  localparam logic [4:0]  RegStatus = 5'd12;

  logic [DEPTH-1:0] v_q, v_d;
  logic [7:0]       addr_q [DEPTH];
  logic [7:0]       addr_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mfc0_hit, eret_hit, addr_eq;

  always_comb begin
    id_cp0_addr = {instrD[2:0], instrD[15:11]};
    id_is_eret  = validD && (instrD == EretWord);
    id_is_mtc0  = validD && (instrD[31:26] == OpCop0) && (instrD[25:21] == RsMt);
    id_is_mfc0  = validD && (instrD[31:26] == OpCop0) && (instrD[25:21] == RsMf);
  end

  always_comb begin
    mfc0_hit = 1'b0;
    eret_hit = 1'b0;
    addr_eq  = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (SEL_CMP != 0) begin
        addr_eq = (addr_q[i] == id_cp0_addr);
      end else begin
        addr_eq = (addr_q[i][4:0] == id_cp0_addr[4:0]);
      end
      if (v_q[i] && addr_eq) begin
        mfc0_hit = 1'b1;
      end
      // ERET reads EPC and Status regardless of sel
      if (v_q[i] && ((addr_q[i][4:0] == RegEpc) || (addr_q[i][4:0] == RegStatus))) begin
        eret_hit = 1'b1;
      end
    end
    stall_cp0 = (id_is_mfc0 && mfc0_hit) || (id_is_eret && eret_hit);
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pend_cnt = pend_cnt + {3'b000, v_q[i]};
    end
  end

  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_d[i] = addr_q[i];
    end
    if (rst) begin
      v_d   = '0;
      cnt_d = '0;
    end else if (flush_all) begin
      v_d = '0;
    end else if (adv) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        v_d[i]    = v_q[i-1];
        addr_d[i] = addr_q[i-1];
      end
      v_d[0]    = id_is_mtc0 && !stall_cp0;
      addr_d[0] = id_cp0_addr;
      if (stall_cp0 && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    v_q   <= v_d;
    cnt_q <= cnt_d;
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_q[i] <= addr_d[i];
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_cp0_priv_hazard.sv
// Bench for cp0_priv_hazard: decode table, directed hazard sequences and a randomized run
// against a queue-based model of pending CP0 writes, across four parameterisations.
module tb_cp0_priv_hazard;

  logic        clk = 1'b0;
  logic        rst, validD, adv, flush_all;
  logic [31:0] instrD;

  logic [3:0]  dec_eret, dec_mtc0, dec_mfc0, stall_v;
  logic [7:0]  addr_v [4];
  logic [3:0]  pend_v [4];
  logic [15:0] cyc16  [4];
  logic [1:0]  cyc2;

  always #5 clk = ~clk;

  cp0_priv_hazard #(.DEPTH(3), .SEL_CMP(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .adv(adv), .flush_all(flush_all),
    .id_is_eret(dec_eret[0]), .id_is_mtc0(dec_mtc0[0]), .id_is_mfc0(dec_mfc0[0]),
    .id_cp0_addr(addr_v[0]), .stall_cp0(stall_v[0]), .pend_cnt(pend_v[0]),
    .stall_cycles(cyc16[0]));
  cp0_priv_hazard #(.DEPTH(3), .SEL_CMP(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .adv(adv), .flush_all(flush_all),
    .id_is_eret(dec_eret[1]), .id_is_mtc0(dec_mtc0[1]), .id_is_mfc0(dec_mfc0[1]),
    .id_cp0_addr(addr_v[1]), .stall_cp0(stall_v[1]), .pend_cnt(pend_v[1]),
    .stall_cycles(cyc16[1]));
  cp0_priv_hazard #(.DEPTH(3), .SEL_CMP(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .adv(adv), .flush_all(flush_all),
    .id_is_eret(dec_eret[2]), .id_is_mtc0(dec_mtc0[2]), .id_is_mfc0(dec_mfc0[2]),
    .id_cp0_addr(addr_v[2]), .stall_cp0(stall_v[2]), .pend_cnt(pend_v[2]),
    .stall_cycles(cyc2));
  cp0_priv_hazard #(.DEPTH(5), .SEL_CMP(1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .adv(adv), .flush_all(flush_all),
    .id_is_eret(dec_eret[3]), .id_is_mtc0(dec_mtc0[3]), .id_is_mfc0(dec_mfc0[3]),
    .id_cp0_addr(addr_v[3]), .stall_cp0(stall_v[3]), .pend_cnt(pend_v[3]),
    .stall_cycles(cyc16[3]));

  assign cyc16[2] = {14'd0, cyc2};

  int n_chk = 0;
  int n_err = 0;

  // Model: one record per pending MTC0 per instance, with its age in advancing edges.
  typedef struct {
    int         inst;
    logic [7:0] addr;
    int         age;
  } ent_t;
  ent_t mq[$];
  int depth_of [4] = '{3, 3, 3, 5};
  int sel_of   [4] = '{1, 0, 1, 1};
  int max_of   [4] = '{65535, 65535, 3, 65535};
  int mcnt     [4] = '{0, 0, 0, 0};
  logic samp_stall [4];
  int   samp_pend  [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_is_mfc0(logic [31:0] ins, logic vld);
    return vld && (ins[31:26] == 6'd16) && (ins[25:21] == 5'd0);
  endfunction
  function automatic bit m_is_mtc0(logic [31:0] ins, logic vld);
    return vld && (ins[31:26] == 6'd16) && (ins[25:21] == 5'd4);
  endfunction
  function automatic bit m_is_eret(logic [31:0] ins, logic vld);
    return vld && (ins == 32'h4200_0018);
  endfunction

  function automatic bit m_stall(int k, logic [31:0] ins, logic vld);
    logic [7:0] a = {ins[2:0], ins[15:11]};
    foreach (mq[j]) begin
      if (mq[j].inst == k) begin
        if (m_is_mfc0(ins, vld) &&
            ((sel_of[k] != 0) ? (mq[j].addr == a) : (mq[j].addr[4:0] == a[4:0])))
          return 1'b1;
        if (m_is_eret(ins, vld) && (mq[j].addr[4:0] == 5'd14 || mq[j].addr[4:0] == 5'd12))
          return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_pend(int k);
    int n = 0;
    foreach (mq[j]) if (mq[j].inst == k) n++;
    return n;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic vld, input logic a, input logic fl,
                       input logic r);
    bit   st [4];
    ent_t nq [$];
    instrD = ins; validD = vld; adv = a; flush_all = fl; rst = r;
    #1;
    chk("id_is_eret", {31'd0, dec_eret[0]}, {31'd0, m_is_eret(ins, vld)});
    chk("id_is_mtc0", {31'd0, dec_mtc0[0]}, {31'd0, m_is_mtc0(ins, vld)});
    chk("id_is_mfc0", {31'd0, dec_mfc0[0]}, {31'd0, m_is_mfc0(ins, vld)});
    chk("id_cp0_addr", {24'd0, addr_v[0]}, {24'd0, ins[2:0], ins[15:11]});
    for (int k = 0; k < 4; k++) begin
      st[k] = m_stall(k, ins, vld);
      samp_stall[k] = stall_v[k];
      samp_pend[k]  = int'(pend_v[k]);
      chk($sformatf("stall_cp0[%0d]", k), {31'd0, stall_v[k]}, {31'd0, st[k]});
      chk($sformatf("pend_cnt[%0d]", k), {28'd0, pend_v[k]}, m_pend(k));
      chk($sformatf("stall_cycles[%0d]", k), {16'd0, cyc16[k]}, mcnt[k]);
    end
    if (r) begin
      mq.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else if (fl) begin
      mq.delete();
    end else if (a) begin
      for (int k = 0; k < 4; k++) if (st[k] && mcnt[k] < max_of[k]) mcnt[k]++;
      foreach (mq[j]) begin
        ent_t e = mq[j];
        e.age++;
        if (e.age < depth_of[e.inst]) nq.push_back(e);
      end
      mq = nq;
      if (m_is_mtc0(ins, vld))
        for (int k = 0; k < 4; k++) mq.push_back('{k, {ins[2:0], ins[15:11]}, 0});
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Mtc12  = 32'h4088_6000;
  localparam logic [31:0] Mtc14  = 32'h4088_7000;
  localparam logic [31:0] Mtc9   = 32'h4088_4800;
  localparam logic [31:0] Mtc12s = 32'h4088_6001;
  localparam logic [31:0] Mfc12  = 32'h4009_6000;
  localparam logic [31:0] Eret   = 32'h4200_0018;
  localparam logic [31:0] Nop    = 32'h0000_0000;

  typedef struct {
    logic [31:0] ins;
    logic        vld;
    logic        e, mt, mf;
    logic [7:0]  addr;
  } vec_t;

  initial begin
    vec_t vt[10];
    int hold;
    vt[0] = '{32'h4200_0018, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{32'h4200_0018, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2] = '{32'h4088_6000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C};
    vt[3] = '{32'h4009_6000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0C};
    vt[4] = '{32'h4088_6001, 1'b1, 1'b0, 1'b1, 1'b0, 8'h2C};
    vt[5] = '{32'h4088_7000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0E};
    vt[6] = '{32'h4200_0019, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20};
    vt[7] = '{32'h8C00_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[8] = '{32'h4009_6000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C};
    vt[9] = '{32'h40A8_6000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0C};

    rst = 1'b1; instrD = Nop; validD = 1'b0; adv = 1'b1; flush_all = 1'b0;
    @(posedge clk);
    #1;

    // Decode table with the tracker held empty
    for (int i = 0; i < 10; i++) begin
      instrD = vt[i].ins; validD = vt[i].vld; adv = 1'b0; rst = 1'b0; flush_all = 1'b0;
      #1;
      chk($sformatf("tbl%0d eret", i), {31'd0, dec_eret[0]}, {31'd0, vt[i].e});
      chk($sformatf("tbl%0d mtc0", i), {31'd0, dec_mtc0[0]}, {31'd0, vt[i].mt});
      chk($sformatf("tbl%0d mfc0", i), {31'd0, dec_mfc0[0]}, {31'd0, vt[i].mf});
      chk($sformatf("tbl%0d addr", i), {24'd0, addr_v[0]}, {24'd0, vt[i].addr});
      chk($sformatf("tbl%0d stall", i), {28'd0, stall_v}, 32'd0);
      chk($sformatf("tbl%0d pend", i), {28'd0, pend_v[0]}, 32'd0);
      chk($sformatf("tbl%0d cyc", i), {16'd0, cyc16[0]}, 32'd0);
      apply(vt[i].ins, vt[i].vld, 1'b0, 1'b0, 1'b0);
    end

    // MTC0 Status then dependent MFC0: 3-cycle stall at DEPTH 3
    apply(Nop, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(Mtc12, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("raw stall c%0d", i), {31'd0, samp_stall[0]}, (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("raw pend c%0d", i), samp_pend[0], (i < 3) ? 32'd1 : 32'd0);
    end
    chk("raw stall_cycles", {16'd0, cyc16[0]}, 32'd3);

    // ERET after MTC0 EPC stalls; after MTC0 rd 9 it does not
    apply(Nop, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(Mtc14, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(Eret, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("eret stall c%0d", i), {31'd0, samp_stall[0]}, (i < 3) ? 32'd1 : 32'd0);
    end
    apply(Mtc9, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(Eret, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("eret rd9 stall", {31'd0, samp_stall[0]}, 32'd0);

    // sel-field match: only the SEL_CMP=0 instance sees a hazard
    apply(Nop, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(Mtc12s, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sel cmp1 stall", {31'd0, samp_stall[0]}, 32'd0);
    chk("sel cmp0 stall", {31'd0, samp_stall[1]}, 32'd1);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sel cmp0 cycles", {16'd0, cyc16[1]}, 32'd3);

    // Freeze mid-stall, then flush
    apply(Nop, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(Mtc12, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    hold = int'(cyc16[0]);
    chk("pre-freeze cycles", hold, 32'd1);
    for (int i = 0; i < 5; i++) begin
      apply(Mfc12, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("freeze stall c%0d", i), {31'd0, samp_stall[0]}, 32'd1);
      chk($sformatf("freeze pend c%0d", i), samp_pend[0], 32'd1);
    end
    chk("freeze cycles", {16'd0, cyc16[0]}, hold);
    apply(Mfc12, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush stall", {31'd0, samp_stall[0]}, 32'd0);
    chk("flush pend", samp_pend[0], 32'd0);

    // Flush in the same cycle as an MTC0 in ID discards it
    apply(Mtc12, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush-mtc0 pend", samp_pend[0], 32'd0);
    chk("flush-mtc0 stall", {31'd0, samp_stall[0]}, 32'd0);

    // Saturation: six stall cycles into a 2-bit counter
    apply(Nop, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      apply(Mtc12, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("sat cnt2", {30'd0, cyc2}, 32'd3);
    chk("sat cnt16", {16'd0, cyc16[0]}, 32'd6);

    // Reset in the middle of a stall
    apply(Mtc12, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst-cycle stall", {31'd0, samp_stall[0]}, 32'd1);
    apply(Mfc12, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post-rst stall", {31'd0, samp_stall[0]}, 32'd0);
    chk("post-rst cycles", {16'd0, cyc16[0]}, 32'd0);

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic [31:0] ins;
      int          kind = $urandom_range(0, 8);
      case ($urandom_range(0, 3))
        0:       rd = 5'd9;
        1:       rd = 5'd12;
        2:       rd = 5'd14;
        default: rd = 5'd13;
      endcase
      sel = 3'($urandom_range(0, 1));
      if (kind < 4)      ins = {6'd16, 5'd4, 5'($urandom), rd, 8'd0, sel};
      else if (kind < 7) ins = {6'd16, 5'd0, 5'($urandom), rd, 8'd0, sel};
      else if (kind < 8) ins = Eret;
      else               ins = $urandom;
      apply(ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_priv_hazard.md
# cp0_priv_hazard

Parametrised successor to the ID-stage privileged-instruction pre-decoder. Sits in the ID stage of the 5-stage MIPS pipeline, next to the main decoder and hazard unit. Decodes COP0 instructions, including the full-word ERET match, and tracks in-flight MTC0 writes between ID and the CP0 commit stage. Stalls ID when an MFC0 or ERET would read a CP0 register that an older MTC0 has not yet committed, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DEPTH, 3, pipeline stages from EX up to and including the CP0 commit stage; range 1..8.
- SEL_CMP, 1, 1 = the sel field (instr[2:0]) takes part in address match; 0 = match on rd only.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instrD  in  32  instruction in ID
- validD  in  1  instrD is a real instruction, not a bubble
- adv  in  1  pipeline advances this cycle; 0 = global freeze
- flush_all  in  1  exception or ERET commit; kills all younger instructions
- id_is_eret  out  1  instrD == 32'h42000018
- id_is_mtc0  out  1  opcode 6'b010000 and rs 5'b00100
- id_is_mfc0  out  1  opcode 6'b010000 and rs 5'b00000
- id_cp0_addr  out  8  {sel, rd} = {instrD[2:0], instrD[15:11]}
- stall_cp0  out  1  hold ID and insert a bubble into EX
- pend_cnt  out  4  number of valid tracked MTC0 entries
- stall_cycles  out  CNT_W  saturating count of cycles with stall_cp0 = 1

## Operation
- Decode is combinational from instrD, gated by validD. All id_is_* outputs are 0 when validD = 0.
- Tracker: DEPTH slots. Each slot holds {v, addr[7:0]}. Slot 0 is the EX-stage instruction; slot DEPTH-1 is the commit stage.
- Address compare:
  - SEL_CMP = 1: compare all 8 bits.
  - SEL_CMP = 0: compare addr[4:0] only.
- stall_cp0 = 1 when either condition holds:
  - id_is_mfc0 and any slot has v = 1 with an address match;
  - id_is_eret and any slot has v = 1 with addr[4:0] equal to 14 (EPC) or 12 (Status).
- A stalled instruction never enters slot 0.
- Slot update per cycle, first matching rule wins:
  1. rst: all v = 0, stall_cycles = 0.
  2. flush_all: all v = 0. stall_cycles is unaffected.
  3. adv = 0: all slots hold.
  4. adv = 1:
     - slot[i].v/addr take slot[i-1] for i ≥ 1; slot DEPTH-1 retires.
     - slot[0].v = id_is_mtc0 & ~stall_cp0; slot[0].addr = id_cp0_addr.
- MTC0 never self-stalls: back-to-back MTC0s each enter the tracker.
- pend_cnt = popcount of slot v bits. It is registered-derived and has no combinational path from instrD.
- stall_cycles increments when stall_cp0 = 1 and adv = 1, and saturates at all-ones. A freeze (adv = 0) does not count.

## Timing
- Reset values: all slots invalid, pend_cnt = 0, stall_cycles = 0. With no valid entries, stall_cp0 = 0 and all decode outputs follow instrD/validD.
- Decode and stall_cp0 are combinational, with zero-cycle latency from instrD.
- An MTC0 accepted at edge N occupies slot 0 after edge N. It leaves slot DEPTH-1 at the DEPTH-th advancing edge.
- Dependent MFC0 stall length: DEPTH advancing cycles when it directly follows the MTC0; one fewer for each independent instruction in between.
- Clearing priority: a flush_all in the same cycle as an accepted MTC0 in ID discards it, because flush dominates adv.
- Reset mid-stall: stall_cp0 drops in the cycle after the rst edge.
- adv = 0 during a stall: stall_cp0 stays 1 and the stall_cycles count freezes.

## Test plan
- Reset, then instrD = 32'h42000018, validD = 1 -> id_is_eret = 1, stall_cp0 = 0, pend_cnt = 0, stall_cycles = 0.
- DEPTH = 3: mtc0 32'h40886000 then mfc0 32'h40096000 next cycle, adv = 1 -> stall_cp0 = 1 for exactly 3 cycles, pend_cnt 1,1,1 then 0, stall_cycles = 3.
- mtc0 32'h40887000 (EPC), then eret -> eret stalls 3 cycles. Repeat with mtc0 to rd = 9 -> no stall.
- mtc0 to {sel 1, rd 12}, then mfc0 {sel 0, rd 12}:
  - SEL_CMP = 1 -> no stall.
  - SEL_CMP = 0 -> 3-cycle stall.
- Stall in progress, hold adv = 0 for 5 cycles -> slots and stall_cycles hold. Assert flush_all -> pend_cnt = 0 and stall_cp0 = 0 on the next cycle.
- CNT_W = 2: force 5 stall cycles -> stall_cycles saturates at 3.
